// File: rtl/pmp_check_arbiter_if.sv
// Bus bundle between the PMP check arbiter, its requesters and the shared
// combinational PMP checker. The arbiter uses the slave view; whatever plays
// the requesters, checker and response sink uses the master view.
interface pmp_check_arbiter_if #(
  parameter int NREQ    = 3,
  parameter int PA_BITS = 56,
  parameter int IDW     = 2
);

  // Requester side
  logic [NREQ-1:0]         ReqValid;
  logic [NREQ-1:0]         ReqReady;
  logic [NREQ*PA_BITS-1:0] ReqAdr;
  logic [NREQ*2-1:0]       ReqType;
  logic [NREQ*2-1:0]       ReqPriv;

  // PMP CSR write notification
  logic                    CfgWrite;

  // Shared checker side
  logic [PA_BITS-1:0]      ChkAdr;
  logic [1:0]              ChkPriv;
  logic                    ChkExecute;
  logic                    ChkWrite;
  logic                    ChkRead;
  logic                    ChkInstrFault;
  logic                    ChkStoreFault;
  logic                    ChkLoadFault;

  // Response side
  logic                    RspValid;
  logic                    RspReady;
  logic [IDW-1:0]          RspId;
  logic                    RspFault;

  modport master (
    output ReqValid, ReqAdr, ReqType, ReqPriv, CfgWrite,
    output ChkInstrFault, ChkStoreFault, ChkLoadFault, RspReady,
    input  ReqReady, ChkAdr, ChkPriv, ChkExecute, ChkWrite, ChkRead,
    input  RspValid, RspId, RspFault
  );

  modport slave (
    input  ReqValid, ReqAdr, ReqType, ReqPriv, CfgWrite,
    input  ChkInstrFault, ChkStoreFault, ChkLoadFault, RspReady,
    output ReqReady, ChkAdr, ChkPriv, ChkExecute, ChkWrite, ChkRead,
    output RspValid, RspId, RspFault
  );

endinterface

// File: rtl/pmp_check_arbiter.sv
// Shares one combinational PMP checker among several physical-address
// requesters. Requests are picked round-robin into an issue stage (S1) that
// drives the checker; the fault result is captured into a one-entry response
// buffer (S2). A small FSM drains S1 and waits one settle cycle after every
// PMP CSR write so no check issues against a half-updated configuration.
module pmp_check_arbiter #(
  parameter int NREQ    = 3,
  parameter int PA_BITS = 56,
  parameter int IDW     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  pmp_check_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SETTLE = 2'd2
  } cfgState_t;

  cfgState_t state;
  cfgState_t nextState;

  // Issue stage
  logic               s1Valid;
  logic [PA_BITS-1:0] s1Adr;
  logic [1:0]         s1Type;
  logic [1:0]         s1Priv;
  logic [IDW-1:0]     s1Id;

  // Response stage
  logic               s2Valid;
  logic [IDW-1:0]     s2Id;
  logic               s2Fault;

  // Index of the most recent winner; the search starts just after it
  logic [IDW-1:0]     lastPtr;

  logic               s2Free;
  logic               s1Adv;
  logic               s1Free;
  logic               canGrant;
  logic               grantFound;
  logic [IDW-1:0]     grantIdx;
  logic [NREQ-1:0]    grantVec;
  logic               accept;
  logic               checkFault;

  // Adds an offset to a requester index and wraps it back into 0..NREQ-1
  function automatic logic [IDW-1:0] wrapIdx(input logic [IDW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NREQ) sum = sum - NREQ;
    return IDW'(sum);
  endfunction

  assign s2Free   = ~s2Valid | bus.RspReady;
  assign s1Adv    = s1Valid & s2Free;
  assign s1Free   = ~s1Valid | s1Adv;
  assign canGrant = s1Free & (state == RUN) & ~bus.CfgWrite;

  // Round-robin search for the first valid requester after the last winner
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grantFound && bus.ReqValid[wrapIdx(lastPtr, k)]) begin
        grantFound = 1'b1;
        grantIdx   = wrapIdx(lastPtr, k);
      end
    end
  end

  // One-hot grant; forced low while reset is asserted so it drops immediately
  always_comb begin
    grantVec = '0;
    if (canGrant && grantFound && !reset) begin
      grantVec[grantIdx] = 1'b1;
    end
  end

  assign accept       = |grantVec;
  assign bus.ReqReady = grantVec;

  // The checker sees the issue stage; type bits are one-hot and idle when S1 is empty
  assign bus.ChkAdr     = s1Adr;
  assign bus.ChkPriv    = s1Priv;
  assign bus.ChkRead    = s1Valid & (s1Type == 2'b00);
  assign bus.ChkWrite   = s1Valid & (s1Type == 2'b01);
  assign bus.ChkExecute = s1Valid & (s1Type == 2'b10);

  // Pick the checker fault matching the access type; the reserved type always faults
  always_comb begin
    checkFault = 1'b1;
    case (s1Type)
      2'b00:   checkFault = bus.ChkLoadFault;
      2'b01:   checkFault = bus.ChkStoreFault;
      2'b10:   checkFault = bus.ChkInstrFault;
      default: checkFault = 1'b1;
    endcase
  end

  // Config sequencing: drain the issue stage, then settle for one cycle
  always_comb begin
    nextState = state;
    case (state)
      RUN: begin
        if (bus.CfgWrite) nextState = DRAIN;
      end
      DRAIN: begin
        if (bus.CfgWrite)  nextState = DRAIN;
        else if (!s1Valid) nextState = SETTLE;
      end
      SETTLE: begin
        if (bus.CfgWrite) nextState = DRAIN;
        else              nextState = RUN;
      end
      default: nextState = RUN;
    endcase
  end

  // Config FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= nextState;
  end

  // Remember the winner only when the grant is actually taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       lastPtr <= IDW'(NREQ - 1);
    else if (accept) lastPtr <= grantIdx;
  end

  // Issue stage: load the winning request, or empty out when it moves on
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1Valid <= 1'b0;
      s1Adr   <= '0;
      s1Type  <= '0;
      s1Priv  <= '0;
      s1Id    <= '0;
    end else if (accept) begin
      s1Valid <= 1'b1;
      s1Adr   <= bus.ReqAdr[int'(grantIdx) * PA_BITS +: PA_BITS];
      s1Type  <= bus.ReqType[int'(grantIdx) * 2 +: 2];
      s1Priv  <= bus.ReqPriv[int'(grantIdx) * 2 +: 2];
      s1Id    <= grantIdx;
    end else if (s1Adv) begin
      s1Valid <= 1'b0;
    end
  end

  // Response stage: capture the fault as S1 advances, release when consumed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2Valid <= 1'b0;
      s2Id    <= '0;
      s2Fault <= 1'b0;
    end else if (s1Adv) begin
      s2Valid <= 1'b1;
      s2Id    <= s1Id;
      s2Fault <= checkFault;
    end else if (bus.RspReady) begin
      s2Valid <= 1'b0;
    end
  end

  assign bus.RspValid = s2Valid;
  assign bus.RspId    = s2Id;
  assign bus.RspFault = s2Fault;

endmodule

// File: tb/tb_pmp_check_arbiter.sv
// Directed bench for pmp_check_arbiter: the bench plays the requesters, the
// PMP checker and the response sink, with hand-computed expectations.
module tb_pmp_check_arbiter;

  localparam int NREQ    = 3;
  localparam int PA_BITS = 56;
  localparam int IDW     = 2;

  // Backpressure scenario, one entry per cycle 0..9
  localparam logic [2:0] BP_VALID  [10] = '{3'b111, 3'b110, 3'b100, 3'b100, 3'b100,
                                            3'b100, 3'b100, 3'b000, 3'b000, 3'b000};
  localparam logic       BP_RREADY [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                            1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam logic       BP_LDF    [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                            1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [2:0] BP_RDY    [10] = '{3'b001, 3'b010, 3'b000, 3'b000, 3'b000,
                                            3'b000, 3'b100, 3'b000, 3'b000, 3'b000};
  localparam logic       BP_RSPV   [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                            1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [1:0] BP_RSPID  [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                                            2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
  localparam logic       BP_RSPF   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                            1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic reset;
  int   checkCount = 0;
  int   errorCount = 0;

  always #5 clk = ~clk;

  pmp_check_arbiter_if #(.NREQ(NREQ), .PA_BITS(PA_BITS), .IDW(IDW)) bus ();

  pmp_check_arbiter #(.NREQ(NREQ), .PA_BITS(PA_BITS), .IDW(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives the per-cycle control inputs and the checker's fault outputs
  task automatic applyStimulus(input logic [2:0] valid, input logic rspReady, input logic cfg,
                               input logic instrF, input logic storeF, input logic loadF);
    bus.ReqValid      = valid;
    bus.RspReady      = rspReady;
    bus.CfgWrite      = cfg;
    bus.ChkInstrFault = instrF;
    bus.ChkStoreFault = storeF;
    bus.ChkLoadFault  = loadF;
  endtask

  task automatic setReq(input int i, input logic [PA_BITS-1:0] adr, input logic [1:0] typ,
                        input logic [1:0] priv);
    bus.ReqAdr[i*PA_BITS +: PA_BITS] = adr;
    bus.ReqType[i*2 +: 2]            = typ;
    bus.ReqPriv[i*2 +: 2]            = priv;
  endtask

  task automatic loadDefaultReqs();
    for (int i = 0; i < NREQ; i++) setReq(i, PA_BITS'(32'h1000 * (i + 1)), 2'b00, 2'b00);
  endtask

  // Moves to the start of the next cycle, just after the rising edge
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Pulses reset across one edge; returns at the start of cycle 0
  task automatic resetDut();
    reset = 1'b1;
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    loadDefaultReqs();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    loadDefaultReqs();
    applyStimulus(3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("reset ReqReady", bus.ReqReady, 3'b000);
    checkOutput("reset RspValid", bus.RspValid, 1'b0);
    checkOutput("reset RspId", bus.RspId, 2'd0);
    checkOutput("reset RspFault", bus.RspFault, 1'b0);
    checkOutput("reset ChkAdr", bus.ChkAdr, 56'h0);
    checkOutput("reset ChkPriv", bus.ChkPriv, 2'd0);
    checkOutput("reset ChkType", {bus.ChkExecute, bus.ChkWrite, bus.ChkRead}, 3'b000);

    // Single request from requester 1
    resetDut();
    setReq(1, 56'h8000_0000, 2'b00, 2'b00);
    applyStimulus(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("single grant", bus.ReqReady, 3'b010);
    nextCycle();
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("single ChkRead", bus.ChkRead, 1'b1);
    checkOutput("single ChkAdr", bus.ChkAdr, 56'h8000_0000);
    checkOutput("single early RspValid", bus.RspValid, 1'b0);
    nextCycle();
    #1;
    checkOutput("single RspValid", bus.RspValid, 1'b1);
    checkOutput("single RspId", bus.RspId, 2'd1);
    checkOutput("single RspFault", bus.RspFault, 1'b1);
    nextCycle();
    #1;
    checkOutput("single consumed", bus.RspValid, 1'b0);

    // Round-robin with all requesters continuously valid
    resetDut();
    for (int c = 0; c < 8; c++) begin
      if (c > 0) nextCycle();
      applyStimulus(3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("rr grant c%0d", c), bus.ReqReady, 3'b001 << (c % 3));
      checkOutput($sformatf("rr RspValid c%0d", c), bus.RspValid, c >= 2);
      if (c >= 1) checkOutput($sformatf("rr ChkAdr c%0d", c), bus.ChkAdr, 64'h1000 * (((c - 1) % 3) + 1));
      if (c >= 2) begin
        checkOutput($sformatf("rr RspId c%0d", c), bus.RspId, (c - 2) % 3);
        checkOutput($sformatf("rr RspFault c%0d", c), bus.RspFault, 1'b0);
      end
    end

    // Backpressure: response held in cycles 2-5
    resetDut();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) nextCycle();
      applyStimulus(BP_VALID[c], BP_RREADY[c], 1'b0, 1'b0, 1'b0, BP_LDF[c]);
      #1;
      checkOutput($sformatf("bp grant c%0d", c), bus.ReqReady, BP_RDY[c]);
      checkOutput($sformatf("bp RspValid c%0d", c), bus.RspValid, BP_RSPV[c]);
      if (BP_RSPV[c]) begin
        checkOutput($sformatf("bp RspId c%0d", c), bus.RspId, BP_RSPID[c]);
        checkOutput($sformatf("bp RspFault c%0d", c), bus.RspFault, BP_RSPF[c]);
      end
      if (c >= 2 && c <= 5) begin
        checkOutput($sformatf("bp ChkAdr hold c%0d", c), bus.ChkAdr, 56'h2000);
        checkOutput($sformatf("bp ChkRead hold c%0d", c), bus.ChkRead, 1'b1);
      end
    end

    // Config write in cycle 5 (run 0), plus a second one in cycle 7 (run 1)
    for (int run = 0; run < 2; run++) begin
      resetDut();
      for (int c = 0; c < 11; c++) begin
        if (c > 0) nextCycle();
        applyStimulus(3'b001, 1'b1, (c == 5) || (run == 1 && c == 7), 1'b0, 1'b0, 1'b0);
        #1;
        if (run == 0 && c < 10)
          checkOutput($sformatf("cfg1 grant c%0d", c), bus.ReqReady, (c < 5 || c >= 8) ? 3'b001 : 3'b000);
        if (run == 1)
          checkOutput($sformatf("cfg2 grant c%0d", c), bus.ReqReady, (c < 5 || c >= 10) ? 3'b001 : 3'b000);
        if (c == 6) checkOutput("cfg drain response", bus.RspValid, 1'b1);
      end
    end

    // Type to fault mapping: execute, reserved, then write
    resetDut();
    setReq(2, 56'hABC000, 2'b10, 2'b11);
    applyStimulus(3'b100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("type grant2", bus.ReqReady, 3'b100);
    nextCycle();
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("type exec ChkType", {bus.ChkExecute, bus.ChkWrite, bus.ChkRead}, 3'b100);
    checkOutput("type exec ChkPriv", bus.ChkPriv, 2'd3);
    checkOutput("type exec ChkAdr", bus.ChkAdr, 56'hABC000);
    nextCycle();
    setReq(0, 56'h5000, 2'b11, 2'b01);
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("type exec RspId", bus.RspId, 2'd2);
    checkOutput("type exec RspFault", bus.RspFault, 1'b0);
    checkOutput("type grant0", bus.ReqReady, 3'b001);
    nextCycle();
    setReq(1, 56'h6000, 2'b01, 2'b00);
    applyStimulus(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("type rsvd ChkType", {bus.ChkExecute, bus.ChkWrite, bus.ChkRead}, 3'b000);
    checkOutput("type grant1", bus.ReqReady, 3'b010);
    nextCycle();
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("type rsvd RspId", bus.RspId, 2'd0);
    checkOutput("type rsvd RspFault", bus.RspFault, 1'b1);
    checkOutput("type write ChkType", {bus.ChkExecute, bus.ChkWrite, bus.ChkRead}, 3'b010);
    nextCycle();
    #1;
    checkOutput("type write RspValid", bus.RspValid, 1'b1);
    checkOutput("type write RspId", bus.RspId, 2'd1);
    checkOutput("type write RspFault", bus.RspFault, 1'b0);

    // Asynchronous reset with both stages full
    resetDut();
    applyStimulus(3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("areset grant0", bus.ReqReady, 3'b001);
    nextCycle();
    applyStimulus(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("areset grant1", bus.ReqReady, 3'b010);
    nextCycle();
    applyStimulus(3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("areset pre RspValid", bus.RspValid, 1'b1);
    checkOutput("areset pre grant2", bus.ReqReady, 3'b100);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("areset RspValid", bus.RspValid, 1'b0);
    checkOutput("areset ReqReady", bus.ReqReady, 3'b000);
    checkOutput("areset ChkAdr", bus.ChkAdr, 56'h0);
    checkOutput("areset ChkType", {bus.ChkExecute, bus.ChkWrite, bus.ChkRead}, 3'b000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("areset first grant", bus.ReqReady, 3'b001);
    nextCycle();
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("areset no stale rsp", bus.RspValid, 1'b0);
    nextCycle();
    #1;
    checkOutput("areset new RspValid", bus.RspValid, 1'b1);
    checkOutput("areset new RspId", bus.RspId, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
